// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Purpose : Shared constants and state encoding for the single-precision
//           post-normalizer datapath.
// Contents: FRAC_W / EXP_W / CNT_W widths, normalizer state typedef,
//           EXP_DENORM exponent value.
// Revision: 1.0  initial release
// ============================================================================
package fp_pkg;

  localparam int FRAC_W = 24;  // fraction width including hidden bit
  localparam int EXP_W  = 8;   // biased exponent width
  localparam int CNT_W  = 5;   // shift-count width, 2**CNT_W > FRAC_W-1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } norm_state_t;

  // Biased exponent value reported for denormal and zero results.
  localparam logic [EXP_W-1:0] EXP_DENORM = '0;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/frac_left_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : frac_left_normalizer
// Purpose : Iterative left normalizer. Shifts an unnormalized fraction left
//           one bit per cycle, decrementing the biased exponent, until the
//           hidden bit is set or the exponent reaches 1 (denormal result).
// Ports   : clk, rst_n            clock, async active-low reset
//           in_valid/in_ready     operand handshake (frac_in, exp_in)
//           out_valid/out_ready   result handshake
//           frac_out, exp_out     normalized fraction / adjusted exponent
//           shift_cnt             number of left shifts applied
//           zero, denorm          result classification flags
// Revision: 1.0  initial release
// ============================================================================
module frac_left_normalizer #(
  parameter int FRAC_W = fp_pkg::FRAC_W,
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int CNT_W  = fp_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              zero,
  output logic              denorm
);

  import fp_pkg::*;

  norm_state_t       state_q, state_d;
  logic [FRAC_W-1:0] frac_q, frac_d;       // working fraction, also the result
  logic [EXP_W-1:0]  exp_q, exp_d;         // working exponent
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic              zero_q, zero_d;
  logic              denorm_q, denorm_d;

  always_comb begin
    state_d   = state_q;
    frac_d    = frac_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    exp_out_d = exp_out_q;
    zero_d    = zero_q;
    denorm_d  = denorm_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          frac_d  = frac_in;
          exp_d   = exp_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Stop conditions are evaluated in strict priority order.
        if (frac_q == '0) begin
          zero_d    = 1'b1;
          denorm_d  = 1'b0;
          exp_out_d = EXP_DENORM;
          state_d   = ST_DONE;
        end else if (exp_q == EXP_DENORM) begin
          // Operand arrived already denormal: pass through unshifted.
          zero_d    = 1'b0;
          denorm_d  = 1'b1;
          exp_out_d = EXP_DENORM;
          state_d   = ST_DONE;
        end else if (frac_q[FRAC_W-1]) begin
          zero_d    = 1'b0;
          denorm_d  = 1'b0;
          exp_out_d = exp_q;
          state_d   = ST_DONE;
        end else if (exp_q == EXP_W'(1)) begin
          // Exponent floor reached before the hidden bit: denormal.
          zero_d    = 1'b0;
          denorm_d  = 1'b1;
          exp_out_d = EXP_DENORM;
          state_d   = ST_DONE;
        end else begin
          // exp_q >= 2 here, so the decrement cannot wrap.
          frac_d = {frac_q[FRAC_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frac_q    <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      exp_out_q <= '0;
      zero_q    <= 1'b0;
      denorm_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frac_q    <= frac_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      exp_out_q <= exp_out_d;
      zero_q    <= zero_d;
      denorm_q  <= denorm_d;
    end
  end

  // Handshake flags decode straight from the state so reset clears them
  // immediately.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign frac_out  = frac_q;
  assign exp_out   = exp_out_q;
  assign shift_cnt = cnt_q;
  assign zero      = zero_q;
  assign denorm    = denorm_q;

endmodule : frac_left_normalizer
`default_nettype wire

// File: tb/tb_frac_left_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_frac_left_normalizer
// Purpose : Self-checking bench for frac_left_normalizer with a behavioural
//           leading-zero model, directed cases and randomized operands.
// Revision: 1.0  initial release
// ============================================================================
module tb_frac_left_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] frac_in = '0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] frac_out;
  logic [7:0]  exp_out;
  logic [4:0]  shift_cnt;
  logic        zero;
  logic        denorm;

  int n_checks = 0;
  int n_err    = 0;

  // Expected result of the operand currently in flight.
  logic [23:0] e_frac;
  logic [7:0]  e_exp;
  logic [4:0]  e_cnt;
  logic        e_zero;
  logic        e_den;

  frac_left_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frac_in   (frac_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frac_out  (frac_out),
    .exp_out   (exp_out),
    .shift_cnt (shift_cnt),
    .zero      (zero),
    .denorm    (denorm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Shift by the leading-zero count, limited so the exponent never drops
  // below 1; the result is normal only if the hidden bit ends up set.
  function automatic void model(input logic [23:0] f, input logic [7:0] e,
                                output logic [23:0] fo, output logic [7:0] eo,
                                output logic [4:0] c, output logic z, output logic d);
    int lz;
    int s;
    fo = f; eo = 8'd0; c = 5'd0; z = 1'b0; d = 1'b0;
    if (f == 24'd0) begin
      z = 1'b1;
    end else if (e == 8'd0) begin
      d = 1'b1;
    end else begin
      lz = 0;
      for (int i = 23; i >= 0; i--) begin
        if (f[i]) break;
        lz++;
      end
      s  = (lz < int'(e) - 1) ? lz : int'(e) - 1;
      fo = f << s;
      c  = 5'(s);
      if (fo[23]) eo = 8'(int'(e) - s);
      else        d  = 1'b1;
    end
  endfunction

  // Checks every cycle a result is presented, including backpressure cycles.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      check("frac_out",  32'(frac_out),  32'(e_frac));
      check("exp_out",   32'(exp_out),   32'(e_exp));
      check("shift_cnt", 32'(shift_cnt), 32'(e_cnt));
      check("zero",      32'(zero),      32'(e_zero));
      check("denorm",    32'(denorm),    32'(e_den));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      check("exclusive", 32'(zero & denorm), 32'd0);
    end
  end

  task automatic do_op(input logic [23:0] f, input logic [7:0] e, input int hold, input bit push2);
    int n;
    int guard;
    model(f, e, e_frac, e_exp, e_cnt, e_zero, e_den);
    @(negedge clk);
    out_ready = 1'b0;
    frac_in   = f;
    exp_in    = e;
    in_valid  = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frac_in  = 24'($urandom);
    exp_in   = 8'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(e_cnt) + 32'd1);
    check("out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (push2) begin
        in_valid = 1'b1;
        frac_in  = 24'h000F00;
        exp_in   = 8'd99;
      end
      check("in_ready_bp", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] pf;
    logic [7:0]  pe;
    logic [4:0]  pc;
    logic        pz;
    logic        pd;
    logic [23:0] rf;
    logic [7:0]  re;

    // Pin the model against hand-computed values.
    model(24'h000001, 8'd100, pf, pe, pc, pz, pd);
    check("model_a_frac", 32'(pf), 32'h800000);
    check("model_a_exp",  32'(pe), 32'd77);
    check("model_a_cnt",  32'(pc), 32'd23);
    model(24'h000100, 8'd3, pf, pe, pc, pz, pd);
    check("model_b_frac", 32'(pf), 32'h000400);
    check("model_b_den",  32'({pd, pz, pe}), 32'h200);
    check("model_b_cnt",  32'(pc), 32'd2);

    // Reset state.
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'({frac_out, exp_out}), 32'd0);
    check("rst_flags", 32'({shift_cnt, zero, denorm}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_op(24'h400000, 8'd10, 0, 1'b0);
    do_op(24'h000001, 8'd100, 0, 1'b0);
    do_op(24'h000100, 8'd3, 0, 1'b0);
    do_op(24'h000000, 8'd50, 0, 1'b0);
    do_op(24'hC00000, 8'd7, 0, 1'b0);
    do_op(24'h123456, 8'd0, 0, 1'b0);
    do_op(24'h000800, 8'd13, 0, 1'b0);   // lands exactly at exp_out=1
    // Backpressure with a second operand pushed while busy.
    do_op(24'h003000, 8'd20, 5, 1'b1);
    do_op(24'h000F00, 8'd99, 0, 1'b0);

    // Asynchronous reset in the middle of a shift sequence.
    @(negedge clk);
    frac_in  = 24'h000010;
    exp_in   = 8'd40;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_cnt",       32'(shift_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(24'h000010, 8'd40, 0, 1'b0);

    // Randomized operands with a spread of leading-zero counts and exponents.
    for (int k = 0; k < 300; k++) begin
      rf = 24'($urandom) >> $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 0) re = 8'($urandom_range(0, 30));
      else                           re = 8'($urandom);
      do_op(rf, re, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_frac_left_normalizer
`default_nettype wire
